// File: rtl/serial_demux_rx_if.sv
// Serial demux receiver bundle: bit-rate enable and serial line in, per-channel data and frame status out.
// Parameters must match the serial_demux_rx instance that uses this interface.
interface serial_demux_rx_if #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 4
) ();
    localparam int NCH = 1 << ADDR_W;

    logic              clkEn;
    logic              SerIn;
    logic [NCH-1:0]    SerOut;
    logic [NCH-1:0]    SerOutValid;
    logic              Done;
    logic              Busy;
    logic [ADDR_W-1:0] PortAddr;
    logic [LEN_W-1:0]  FrameLen;
    logic              ParityErr;

    // master drives the line (pin side), slave is the receiver
    modport master (
        output clkEn, SerIn,
        input  SerOut, SerOutValid, Done, Busy, PortAddr, FrameLen, ParityErr
    );

    modport slave (
        input  clkEn, SerIn,
        output SerOut, SerOutValid, Done, Busy, PortAddr, FrameLen, ParityErr
    );
endinterface

// File: rtl/serial_demux_rx.sv
// Serial frame receiver: start bit, MSB-first address and length fields, then N data bits routed to one channel.
// Optional even-parity check over address, length and data bits is enabled with `define SERIAL_DEMUX_PARITY_EN.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line idle, waiting for a low start bit
// S_ADDR   | shifting in the ADDR_W-bit port address
// S_LEN    | shifting in the LEN_W-bit data length
// S_DATA   | routing data bits to SerOut[PortAddr]
// S_PARITY | sampling the even-parity bit (parity build only)
// S_DONE   | end-of-frame, Done high for one enabled period
module serial_demux_rx #(
    parameter int ADDR_W = 2,
    parameter int LEN_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    serial_demux_rx_if.slave  bus
);
    localparam int NCH     = 1 << ADDR_W;
    localparam int CNT_MAX = (ADDR_W > LEN_W) ? ADDR_W : LEN_W;
    localparam int CNT_W   = ($clog2(CNT_MAX) > 0) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LEN,
        S_DATA,
        S_DONE
`ifdef SERIAL_DEMUX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

`ifdef SERIAL_DEMUX_PARITY_EN
    localparam state_t S_TAIL = S_PARITY;
`else
    localparam state_t S_TAIL = S_DONE;
`endif

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  data_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [NCH-1:0]    ser_out;
    logic [NCH-1:0]    ser_valid;
    logic [ADDR_W-1:0] addr_shift;
    logic [LEN_W-1:0]  len_shift;
    logic [NCH-1:0]    addr_onehot;
    logic              done;
    logic              busy;
`ifdef SERIAL_DEMUX_PARITY_EN
    logic              par_acc;
    logic              parity_err;
`endif

    // field values including the bit being sampled on this edge
    assign addr_shift  = ADDR_W'({addr_q, bus.SerIn});
    assign len_shift   = LEN_W'({len_q, bus.SerIn});
    assign addr_onehot = NCH'(1) << addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = (state == S_DONE);
        busy      = (state != S_IDLE);
        if (bus.clkEn) begin
            case (state)
                S_IDLE: if (!bus.SerIn) state_nxt = S_ADDR;
                S_ADDR: if (bit_cnt == '0) state_nxt = S_LEN;
                S_LEN: begin
                    if (bit_cnt == '0) begin
                        state_nxt = (len_shift == '0) ? S_TAIL : S_DATA;
                    end
                end
                S_DATA: if (data_cnt == LEN_W'(1)) state_nxt = S_TAIL;
`ifdef SERIAL_DEMUX_PARITY_EN
                S_PARITY: state_nxt = S_DONE;
`endif
                S_DONE: state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt    <= '0;
            data_cnt   <= '0;
            addr_q     <= '0;
            len_q      <= '0;
            ser_out    <= '0;
            ser_valid  <= '0;
`ifdef SERIAL_DEMUX_PARITY_EN
            par_acc    <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else if (bus.clkEn) begin
            // valid lasts exactly one enabled period unless another data bit lands
            ser_valid <= '0;
            case (state)
                S_IDLE: begin
                    if (!bus.SerIn) begin
                        bit_cnt <= CNT_W'(ADDR_W - 1);
                        addr_q  <= '0;
                        len_q   <= '0;
`ifdef SERIAL_DEMUX_PARITY_EN
                        par_acc    <= 1'b0;
                        parity_err <= 1'b0;
`endif
                    end
                end
                S_ADDR: begin
                    addr_q <= addr_shift;
`ifdef SERIAL_DEMUX_PARITY_EN
                    par_acc <= par_acc ^ bus.SerIn;
`endif
                    if (bit_cnt == '0) begin
                        bit_cnt <= CNT_W'(LEN_W - 1);
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                S_LEN: begin
                    len_q <= len_shift;
`ifdef SERIAL_DEMUX_PARITY_EN
                    par_acc <= par_acc ^ bus.SerIn;
`endif
                    if (bit_cnt == '0) begin
                        data_cnt <= len_shift;
                    end else begin
                        bit_cnt <= bit_cnt - CNT_W'(1);
                    end
                end
                S_DATA: begin
                    ser_out[addr_q] <= bus.SerIn;
                    ser_valid       <= addr_onehot;
                    data_cnt        <= data_cnt - LEN_W'(1);
`ifdef SERIAL_DEMUX_PARITY_EN
                    par_acc <= par_acc ^ bus.SerIn;
`endif
                end
`ifdef SERIAL_DEMUX_PARITY_EN
                S_PARITY: parity_err <= par_acc ^ bus.SerIn;
`endif
                default: ;
            endcase
        end
    end

    assign bus.SerOut      = ser_out;
    assign bus.SerOutValid = ser_valid;
    assign bus.Done        = done;
    assign bus.Busy        = busy;
    assign bus.PortAddr    = addr_q;
    assign bus.FrameLen    = len_q;
`ifdef SERIAL_DEMUX_PARITY_EN
    assign bus.ParityErr   = parity_err;
`else
    assign bus.ParityErr   = 1'b0;
`endif
endmodule
